// File: rtl/char_bus_arbiter.sv
// rtl/char_bus_arbiter.sv - character RAM arbiter, display fetch over queued host requests
// Display strobes always win the RAM slot; host requests wait in a small FIFO.

module char_bus_req_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic         video_clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = DEPTH[PTR_W:0];

  logic [W-1:0]     slots [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  assign head  = slots[rd_ptr];
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  always_ff @(posedge video_clk) begin
    if (push) slots[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module char_bus_arbiter #(
  parameter int ADDR_W     = 11,
  parameter int DATA_W     = 16,
  parameter int CELLS      = 2400,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              video_clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_we,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [DATA_W-1:0] host_req_wdata,
  output logic              host_rsp_valid,
  output logic              host_rsp_err,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              host_idle,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int ENT_W = 1 + ADDR_W + DATA_W;
  localparam logic [ADDR_W:0] CELL_LIMIT = CELLS[ADDR_W:0];

  typedef enum logic [2:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_HOST_RD,
    TAG_HOST_WR,
    TAG_HOST_ERR
  } tag_t;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic              host_push;
  logic [ENT_W-1:0]  fifo_head;
  logic              head_we;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_wdata;

  tag_t              issue_tag;
  logic              issue_we;
  logic [ADDR_W-1:0] issue_addr;
  logic [DATA_W-1:0] issue_wdata;

  tag_t tag_s0;
  tag_t tag_s1;
  tag_t tag_s2;

  function automatic logic is_host(input tag_t t);
    return (t == TAG_HOST_RD) || (t == TAG_HOST_WR) || (t == TAG_HOST_ERR);
  endfunction

  assign host_req_ready = !fifo_full;
  assign host_push      = host_req_valid && !fifo_full;
  assign {head_we, head_addr, head_wdata} = fifo_head;

  char_bus_req_fifo #(
    .W     (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .video_clk (video_clk),
    .reset     (reset),
    .push      (host_push),
    .push_data ({host_req_we, host_req_addr, host_req_wdata}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Slot decision: display first, then FIFO head; an idle slot leaves the address bus parked.
  always_comb begin
    fifo_pop    = 1'b0;
    issue_tag   = TAG_NONE;
    issue_we    = 1'b0;
    issue_addr  = mem_addr;
    issue_wdata = mem_wdata;
    if (disp_req) begin
      issue_tag  = TAG_DISP;
      issue_addr = disp_addr;
    end else if (!fifo_empty) begin
      fifo_pop = 1'b1;
      if ({1'b0, head_addr} < CELL_LIMIT) begin
        issue_tag   = head_we ? TAG_HOST_WR : TAG_HOST_RD;
        issue_we    = head_we;
        issue_addr  = head_addr;
        issue_wdata = head_wdata;
      end else begin
        issue_tag = TAG_HOST_ERR;
      end
    end
  end

  // tag_s0 travels with mem_*; tag_s2 lines up with mem_rdata from the RAM's output register.
  always_ff @(posedge video_clk) begin
    if (reset) begin
      mem_addr       <= '0;
      mem_we         <= 1'b0;
      mem_wdata      <= '0;
      tag_s0         <= TAG_NONE;
      tag_s1         <= TAG_NONE;
      tag_s2         <= TAG_NONE;
      disp_valid     <= 1'b0;
      disp_data      <= '0;
      host_rsp_valid <= 1'b0;
      host_rsp_err   <= 1'b0;
      host_rsp_data  <= '0;
      host_idle      <= 1'b1;
    end else begin
      mem_addr       <= issue_addr;
      mem_we         <= issue_we;
      mem_wdata      <= issue_wdata;
      tag_s0         <= issue_tag;
      tag_s1         <= tag_s0;
      tag_s2         <= tag_s1;
      disp_valid     <= (tag_s2 == TAG_DISP);
      disp_data      <= (tag_s2 == TAG_DISP) ? mem_rdata : '0;
      host_rsp_valid <= is_host(tag_s2);
      host_rsp_err   <= (tag_s2 == TAG_HOST_ERR);
      host_rsp_data  <= (tag_s2 == TAG_HOST_RD) ? mem_rdata : '0;
      host_idle      <= fifo_empty && !host_push &&
                        !is_host(tag_s0) && !is_host(tag_s1) && !is_host(tag_s2);
    end
  end
endmodule

// File: tb/tb_char_bus_arbiter.sv
// tb/tb_char_bus_arbiter.sv - scoreboard bench for char_bus_arbiter with a transaction-level model
module tb_char_bus_arbiter;
  localparam int AW     = 12;
  localparam int DW     = 16;
  localparam int NCELLS = 2400;
  localparam int FD     = 4;

  logic          video_clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic          disp_valid;
  logic [DW-1:0] disp_data;
  logic          host_req_valid = 1'b0;
  logic          host_req_ready;
  logic          host_req_we = 1'b0;
  logic [AW-1:0] host_req_addr = '0;
  logic [DW-1:0] host_req_wdata = '0;
  logic          host_rsp_valid;
  logic          host_rsp_err;
  logic [DW-1:0] host_rsp_data;
  logic          host_idle;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  int edge_cnt = 0;

  always #5 video_clk = ~video_clk;

  char_bus_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .CELLS      (NCELLS),
    .FIFO_DEPTH (FD)
  ) dut (
    .video_clk      (video_clk),
    .reset          (reset),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_valid     (disp_valid),
    .disp_data      (disp_data),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_req_we    (host_req_we),
    .host_req_addr  (host_req_addr),
    .host_req_wdata (host_req_wdata),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_err   (host_rsp_err),
    .host_rsp_data  (host_rsp_data),
    .host_idle      (host_idle),
    .mem_addr       (mem_addr),
    .mem_we         (mem_we),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  // Character RAM: samples mem_* one edge after issue, data out through an output register.
  logic [DW-1:0] ram [1<<AW];
  logic [DW-1:0] rd_q = '0;
  always @(posedge video_clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    rd_q      <= ram[mem_addr];
    mem_rdata <= rd_q;
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  typedef struct {
    int            cyc;
    logic          err;
    logic [DW-1:0] data;
  } exp_t;

  req_t          mq[$];
  exp_t          host_exp[$];
  exp_t          disp_exp[$];
  logic [DW-1:0] cmem [1<<AW];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: each edge, display wins the slot, otherwise the oldest queued request
  // completes against the model memory; results are due three edges later.
  always @(posedge video_clk) begin
    bit   accept;
    req_t r;
    edge_cnt++;
    if (reset) begin
      mq.delete();
      host_exp.delete();
      disp_exp.delete();
    end else begin
      accept = host_req_valid && (mq.size() < FD);
      if (disp_req) begin
        disp_exp.push_back(exp_t'{edge_cnt + 3, 1'b0, cmem[disp_addr]});
      end else if (mq.size() > 0) begin
        r = mq.pop_front();
        if (int'(r.addr) >= NCELLS) begin
          host_exp.push_back(exp_t'{edge_cnt + 3, 1'b1, '0});
        end else if (r.we) begin
          cmem[r.addr] = r.wdata;
          host_exp.push_back(exp_t'{edge_cnt + 3, 1'b0, '0});
        end else begin
          host_exp.push_back(exp_t'{edge_cnt + 3, 1'b0, cmem[r.addr]});
        end
      end
      if (accept) mq.push_back(req_t'{host_req_we, host_req_addr, host_req_wdata});
    end
  end

  // Monitor
  always @(negedge video_clk) begin
    exp_t e;
    bit   host_due;
    bit   disp_due;
    host_due = (host_exp.size() > 0) && (host_exp[0].cyc == edge_cnt);
    disp_due = (disp_exp.size() > 0) && (disp_exp[0].cyc == edge_cnt);
    if (host_due || host_rsp_valid) check("host_rsp_valid", int'(host_rsp_valid), int'(host_due));
    if (host_due) begin
      e = host_exp.pop_front();
      if (host_rsp_valid) begin
        check("host_rsp_err", int'(host_rsp_err), int'(e.err));
        check("host_rsp_data", int'(host_rsp_data), int'(e.data));
      end
    end
    if (disp_due || disp_valid) check("disp_valid", int'(disp_valid), int'(disp_due));
    if (disp_due) begin
      e = disp_exp.pop_front();
      if (disp_valid) check("disp_data", int'(disp_data), int'(e.data));
    end
    check("host_req_ready", int'(host_req_ready), int'(mq.size() < FD));
    if (mem_we) check("mem_we_in_range", int'(int'(mem_addr) < NCELLS), 1);
  end

  task automatic drive(input logic dr, input int da, input logic v, input logic we,
                       input int a, input logic [DW-1:0] d);
    disp_req       = dr;
    disp_addr      = AW'(da);
    host_req_valid = v;
    host_req_we    = we;
    host_req_addr  = AW'(a);
    host_req_wdata = d;
    @(negedge video_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 1'b0, 1'b0, 0, '0);
  endtask

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [DW-1:0] v;
    logic [DW-1:0] burst [5];
    for (int i = 0; i < (1 << AW); i++) begin
      v       = DW'($urandom);
      ram[i]  = v;
      cmem[i] = v;
    end

    reset = 1'b1;
    repeat (3) @(negedge video_clk);
    check("rst_disp_valid", int'(disp_valid), 0);
    check("rst_disp_data", int'(disp_data), 0);
    check("rst_rsp_valid", int'(host_rsp_valid), 0);
    check("rst_rsp_err", int'(host_rsp_err), 0);
    check("rst_rsp_data", int'(host_rsp_data), 0);
    check("rst_mem_we", int'(mem_we), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_mem_wdata", int'(mem_wdata), 0);
    check("rst_ready", int'(host_req_ready), 1);
    check("rst_idle", int'(host_idle), 1);
    reset = 1'b0;

    // Single write to cell 0 and the idle window around it
    drive(1'b0, 0, 1'b1, 1'b1, 0, 16'h0741);
    check("t1_idle_after_push", int'(host_idle), 0);
    idle(1);
    check("t1_mem_we", int'(mem_we), 1);
    check("t1_mem_addr", int'(mem_addr), 0);
    idle(3);
    check("t1_rsp_at_pop_plus3", int'(host_rsp_valid), 1);
    check("t1_idle_during_rsp", int'(host_idle), 0);
    idle(1);
    check("t1_idle_after_rsp", int'(host_idle), 1);
    check("t1_ram0", int'(ram[0]), 16'h0741);

    // Write then read back the same cell
    drive(1'b0, 0, 1'b1, 1'b1, 163, 16'h0A4D);
    drive(1'b0, 0, 1'b1, 1'b0, 163, '0);
    idle(8);

    // Display and host request in the same cycle
    drive(1'b1, 0, 1'b1, 1'b0, 163, '0);
    idle(8);

    // Display held high while five pushes are attempted
    for (int k = 0; k < 5; k++) begin
      burst[k] = DW'($urandom);
      drive(1'b1, k * 7, 1'b1, 1'b1, 200 + k, burst[k]);
    end
    check("t4_ready_full", int'(host_req_ready), 0);
    check("t4_no_write_yet", int'(ram[200]), int'(cmem[200]));
    idle(12);
    check("t4_ram203", int'(ram[203]), int'(burst[3]));
    check("t4_ram204_untouched", int'(ram[204]), int'(cmem[204]));

    // Out-of-range write
    v = ram[2400];
    drive(1'b0, 0, 1'b1, 1'b1, 2400, 16'hBEEF);
    idle(8);
    check("t5_ram2400_unchanged", int'(ram[2400]), int'(v));

    // Reset with two queued and one in flight
    drive(1'b1, 5, 1'b1, 1'b0, 10, '0);
    drive(1'b1, 6, 1'b1, 1'b1, 11, 16'h1234);
    drive(1'b1, 7, 1'b1, 1'b0, 12, '0);
    idle(1);
    reset = 1'b1;
    idle(2);
    check("t6_ready", int'(host_req_ready), 1);
    check("t6_idle", int'(host_idle), 1);
    reset = 1'b0;
    idle(10);
    check("t6_idle_after", int'(host_idle), 1);
    check("t6_ram11_unwritten", int'(ram[11]), int'(cmem[11]));

    // Randomized traffic
    repeat (600) begin
      drive(1'($urandom_range(0, 3) == 0), int'($urandom_range(0, NCELLS - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 2499)), DW'($urandom));
    end
    idle(12);
    check("rand_idle_final", int'(host_idle), 1);
    check("rand_host_drained", host_exp.size(), 0);
    check("rand_disp_drained", disp_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
